compare_iter: RTL and testbench

//  Parametrised multi-cycle magnitude comparator: successor to the single-cycle signed/unsigned compare.

---
 rtl/compare_iter.sv | 158 +++++++++++++++
 tb/tb_compare_iter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_iter.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands one CHUNK-bit slice per cycle,
// MSB slice first, finishing at the first differing slice. Signed mode uses an offset-binary rewrite.
module compare_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_less,
    output logic             o_equal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP  = IW'(NCHUNK - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("compare_iter: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;

    logic [CHUNK-1:0] a_slice_s, b_slice_s;
    logic             slice_ne_s, slice_lt_s, accept_s;
    logic [WIDTH-1:0] sign_flip_s;

    assign accept_s   = i_valid && ready_q;
    assign a_slice_s  = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_slice_s  = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_ne_s = (a_slice_s != b_slice_s);
    assign slice_lt_s = (a_slice_s < b_slice_s);
    // Flipping the sign bit maps two's complement onto unsigned order.
    assign sign_flip_s = {i_signed, {(WIDTH-1){1'b0}}};

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_less  = less_q;
    assign o_equal = equal_q;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (slice_ne_s || (idx_q == IDX_ZERO)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-values; handshake flags are registered from the next state.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        less_d  = less_q;
        equal_d = equal_q;
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_d   = i_operand_a ^ sign_flip_s;
                    b_d   = i_operand_b ^ sign_flip_s;
                    idx_d = IDX_TOP;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_RUN: begin
                if (slice_ne_s) begin
                    less_d  = slice_lt_s;
                    equal_d = 1'b0;
                end else if (idx_q == IDX_ZERO) begin
                    less_d  = 1'b0;
                    equal_d = 1'b1;
                end else begin
                    idx_d = idx_q - {{(IW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                idx_d = idx_q;
            end
            default: begin
                idx_d = IDX_ZERO;
            end
        endcase
    end

    // Datapath and registered output flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            idx_q   <= IDX_ZERO;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            less_q  <= less_d;
            equal_q <= equal_d;
        end
    end

endmodule

// File: tb/tb_compare_iter.sv
// Randomised bench for compare_iter: a CHUNK=8 and a CHUNK=32 instance checked every cycle against
// an arithmetic reference model, plus directed cases with hand-computed results and latencies.
module tb_compare_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_in [2];
    logic        rdy_o [2];
    logic        vo [2];
    logic        ri [2];
    logic        s_in [2];
    logic        less_o [2];
    logic        eq_o [2];
    logic [31:0] a_in [2];
    logic [31:0] b_in [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compare_iter #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[0]), .o_ready(rdy_o[0]),
        .i_operand_a(a_in[0]), .i_operand_b(b_in[0]), .i_signed(s_in[0]),
        .o_valid(vo[0]), .i_ready(ri[0]), .o_less(less_o[0]), .o_equal(eq_o[0])
    );

    compare_iter #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[1]), .o_ready(rdy_o[1]),
        .i_operand_a(a_in[1]), .i_operand_b(b_in[1]), .i_signed(s_in[1]),
        .o_valid(vo[1]), .i_ready(ri[1]), .o_less(less_o[1]), .o_equal(eq_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Reference: plain arithmetic compare; latency = position of first differing chunk from the top.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  input int n, output logic less, output logic eq, output int lat);
        int w;
        logic [31:0] x;
        bit found;
        w = 32 / n;
        x = a ^ b;
        eq = (a == b);
        less = s ? ($signed(a) < $signed(b)) : (a < b);
        lat = n;
        found = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (!found && ((x >> (32 - w * k)) != 32'd0)) begin
                lat = k;
                found = 1'b1;
            end
        end
    endfunction

    // Per-instance model state
    bit   busy [2]     = '{1'b0, 1'b0};
    bit   acc_pend [2] = '{1'b0, 1'b0};
    bit   hs_pend [2]  = '{1'b0, 1'b0};
    bit   rst_gap [2]  = '{1'b1, 1'b1};
    int   cnt [2]      = '{0, 0};
    int   mlat [2]     = '{0, 0};
    logic mless [2]    = '{1'b0, 1'b0};
    logic meq [2]      = '{1'b0, 1'b0};
    logic lless [2]    = '{1'b0, 1'b0};
    logic leq [2]      = '{1'b0, 1'b0};

    // Compare process: advances the model by one clock and checks every output of both instances.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("rst_valid", 32'(vo[d]), 32'd0);
                chk("rst_ready", 32'(rdy_o[d]), 32'd0);
                chk("rst_less", 32'(less_o[d]), 32'd0);
                chk("rst_equal", 32'(eq_o[d]), 32'd0);
                busy[d] = 1'b0; acc_pend[d] = 1'b0; hs_pend[d] = 1'b0;
                rst_gap[d] = 1'b1; lless[d] = 1'b0; leq[d] = 1'b0;
            end else begin
                logic ev;
                if (acc_pend[d]) begin
                    busy[d] = 1'b1;
                    cnt[d] = 0;
                end else if (hs_pend[d]) begin
                    busy[d] = 1'b0;
                    lless[d] = mless[d];
                    leq[d] = meq[d];
                end else if (busy[d]) begin
                    cnt[d]++;
                end
                acc_pend[d] = 1'b0;
                hs_pend[d] = 1'b0;
                ev = busy[d] && (cnt[d] >= mlat[d]);
                chk("valid", 32'(vo[d]), 32'(ev));
                chk("ready", 32'(rdy_o[d]), 32'(!busy[d] && !rst_gap[d]));
                if (ev) begin
                    chk("less", 32'(less_o[d]), 32'(mless[d]));
                    chk("equal", 32'(eq_o[d]), 32'(meq[d]));
                end else begin
                    chk("held_less", 32'(less_o[d]), 32'(lless[d]));
                    chk("held_equal", 32'(eq_o[d]), 32'(leq[d]));
                end
                if (!busy[d] && !rst_gap[d] && v_in[d]) begin
                    acc_pend[d] = 1'b1;
                    model(a_in[d], b_in[d], s_in[d], nch(d), mless[d], meq[d], mlat[d]);
                end
                if (ev && ri[d]) hs_pend[d] = 1'b1;
                rst_gap[d] = 1'b0;
            end
        end
    end

    // One request: wait for accept, scramble inputs in flight, apply bp cycles of backpressure.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int bp, output logic less, output logic eq, output int lat);
        bit got;
        @(posedge clk); #2;
        a_in[d] = a; b_in[d] = b; s_in[d] = s; v_in[d] = 1'b1; ri[d] = (bp == 0);
        got = 1'b0; less = 1'b0; eq = 1'b0; lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rdy_o[d]) got = 1'b1;
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            v_in[d] = 1'b0;
            return;
        end
        @(posedge clk); #2;
        v_in[d] = 1'b0; a_in[d] = $urandom; b_in[d] = $urandom; s_in[d] = 1'($urandom);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (vo[d]) got = 1'b1;
            #1;
            a_in[d] = $urandom; b_in[d] = $urandom; s_in[d] = 1'($urandom);
            v_in[d] = (bp > 0) ? 1'($urandom) : 1'b0;
        end
        if (!got) chk("result_timeout", 32'd0, 32'd1);
        less = less_o[d];
        eq = eq_o[d];
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #2;
            a_in[d] = $urandom; b_in[d] = $urandom; s_in[d] = 1'($urandom);
            v_in[d] = 1'($urandom);
        end
        v_in[d] = 1'b0;
        ri[d] = 1'b1;
        @(posedge clk); #2;
        ri[d] = 1'b0;
    endtask

    task automatic dir(input string name, input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int bp, input logic el, input logic ee, input int elat);
        logic l, e;
        int lt;
        send(d, a, b, s, bp, l, e, lt);
        chk({name, "_less"}, 32'(l), 32'(el));
        chk({name, "_equal"}, 32'(e), 32'(ee));
        chk({name, "_lat"}, 32'(lt), 32'(elat));
    endtask

    initial begin
        logic ml, me;
        int mlt;
        logic [31:0] ra, rb;
        logic l, e;
        int lt;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            v_in[d] = 1'b0; ri[d] = 1'b0; s_in[d] = 1'b0; a_in[d] = 32'd0; b_in[d] = 32'd0;
        end

        model(32'hFFFFFFFF, 32'h00000001, 1'b1, 4, ml, me, mlt);
        chk("pin_m1_less", 32'(ml), 32'd1);
        chk("pin_m1_lat", 32'(mlt), 32'd1);
        model(32'h12005678, 32'h12FF0000, 1'b0, 4, ml, me, mlt);
        chk("pin_m2_less", 32'(ml), 32'd1);
        chk("pin_m2_lat", 32'(mlt), 32'd2);
        model(32'h12345678, 32'h12345678, 1'b1, 4, ml, me, mlt);
        chk("pin_m3_equal", 32'(me), 32'd1);
        chk("pin_m3_lat", 32'(mlt), 32'd4);

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        dir("t1_signed",   0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 1'b1, 1'b0, 1);
        dir("t1_unsigned", 0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b0, 1);
        dir("t2_signed",   0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 0, 1'b1, 1'b0, 1);
        dir("t2_unsigned", 0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 0, 1'b0, 1'b0, 1);
        dir("t3_signed",   0, 32'h12345678, 32'h12345678, 1'b1, 0, 1'b0, 1'b1, 4);
        dir("t3_unsigned", 0, 32'h12345678, 32'h12345678, 1'b0, 0, 1'b0, 1'b1, 4);
        dir("t4_lo_less",  0, 32'h12345600, 32'h12345601, 1'b0, 0, 1'b1, 1'b0, 4);
        dir("t4_lo_gt",    0, 32'h12345601, 32'h12345600, 1'b0, 0, 1'b0, 1'b0, 4);
        dir("t5_backpr",   0, 32'h12005678, 32'h12FF0000, 1'b0, 10, 1'b1, 1'b0, 2);
        dir("c32_equal",   1, 32'h12345678, 32'h12345678, 1'b0, 0, 1'b0, 1'b1, 1);
        dir("c32_less",    1, 32'h12345600, 32'h12345601, 1'b0, 2, 1'b1, 1'b0, 1);
        dir("c32_signed",  1, 32'h80000000, 32'h00000000, 1'b1, 0, 1'b1, 1'b0, 1);

        // Reset in the middle of an equal-operand run, with a less=1 result still on the outputs.
        dir("t6_pre", 0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 1'b1, 1'b0, 1);
        @(posedge clk); #2;
        a_in[0] = 32'h12345678; b_in[0] = 32'h12345678; s_in[0] = 1'b1; v_in[0] = 1'b1;
        @(posedge clk); #2;
        v_in[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(vo[0]), 32'd0);
        chk("t6_async_less", 32'(less_o[0]), 32'd0);
        chk("t6_async_equal", 32'(eq_o[0]), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        dir("t6_after", 0, 32'hFFFFFFFB, 32'h00000003, 1'b1, 0, 1'b1, 1'b0, 1);

        for (int it = 0; it < 150; it++) begin
            int d;
            d = int'($urandom % 2);
            ra = $urandom;
            rb = ra;
            for (int k = 0; k < 4; k++) begin
                if (($urandom % 3) == 0) rb[8*k +: 8] = 8'($urandom);
            end
            if (($urandom % 8) == 0) rb = ra ^ 32'h80000000;
            if (($urandom % 8) == 0) rb = $urandom;
            send(d, ra, rb, 1'($urandom), int'($urandom % 4), l, e, lt);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
